// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t : per-access FSM states
//   grant_t     : which requester owns the current access
//   F3_*        : RV32 load/store func3 width codes
//   LANES       : byte lanes in one 32-bit RAM word
`timescale 1ns/1ps
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  typedef enum logic {GNT_CORE, GNT_LDR} grant_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LANES = 4;

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: combinational byte-lane formatter for one RAM word.
// Ports:
//   func3      in  : RV32 load/store width code
//   is_write   in  : 1 = store, 0 = load (BU/HU codes only mean something for loads)
//   addr_lo    in  : byte offset within the word
//   wdata      in  : LSB-aligned store data
//   rdata      in  : raw RAM word
//   we         out : byte write enables for a store
//   wdata_sh   out : store data replicated onto every lane
//   rdata_ext  out : selected load data, sign- or zero-extended
//   misaligned out : halfword at odd address or word not on a word boundary
// Unknown func3 codes fall through to full-word behaviour; a misaligned
// halfword/word is force-aligned by simply ignoring the low address bits.
`timescale 1ns/1ps
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]       func3,
  input  logic             is_write,
  input  logic [1:0]       addr_lo,
  input  logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  output logic [LANES-1:0] we,
  output logic [31:0]      wdata_sh,
  output logic [31:0]      rdata_ext,
  output logic             misaligned
);

  logic       is_byte;
  logic       is_half;
  logic [7:0] rd_byte;
  logic [15:0] rd_half;

  // Decode the access width, then build lane enables, replicated store
  // data and the extended load value for that width.
  always_comb begin
    is_byte    = (func3 == F3_B) || (!is_write && func3 == F3_BU);
    is_half    = (func3 == F3_H) || (!is_write && func3 == F3_HU);
    rd_byte    = rdata[8*addr_lo +: 8];
    rd_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    we         = 4'b1111;
    wdata_sh   = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    if (is_byte) begin
      we        = 4'b0001 << addr_lo;
      wdata_sh  = {4{wdata[7:0]}};
      rdata_ext = func3[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
    end else if (is_half) begin
      we         = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata_sh   = {2{wdata[15:0]}};
      rdata_ext  = func3[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      misaligned = addr_lo[0];
    end else begin
      misaligned = |addr_lo;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port fixed-latency data RAM between the
// core MEM stage and a word-wide loader port, with round-robin arbitration.
// Ports:
//   clk, rstN                     : clock, asynchronous active-low reset
//   core_read/core_write          : core request levels, held until core_ready
//   core_func3/addr/wdata         : core access width, byte address, store data
//   core_rdata/core_ready         : formatted load data and completion pulse
//   core_err                      : misalignment trap pulse (optional build)
//   ldr_valid/write/addr/wdata    : loader word request
//   ldr_rdata/ldr_ready           : loader read data and completion pulse
//   mem_en/we/addr/wdata/rdata    : RAM macro interface
// Optional feature: define DMEM_MISALIGN_TRAP_EN to add core_err and reject
// misaligned halfword/word core accesses instead of force-aligning them.
`timescale 1ns/1ps
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  core_read,
  input  logic                  core_write,
  input  logic [2:0]            core_func3,
  input  logic [31:0]           core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_ready,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic                  core_err,
`endif
  input  logic                  ldr_valid,
  input  logic                  ldr_write,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  output logic [DATA_WIDTH-1:0] ldr_rdata,
  output logic                  ldr_ready,
  output logic                  mem_en,
  output logic [LANES-1:0]      mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  arb_state_t state;
  grant_t     last_grant;
  grant_t     gnt;
  logic       wr_q;
  logic [2:0] func3_q;
  logic [1:0] lo_q;
  logic [2:0] cnt;
  logic       trap_q;
  logic       err_pulse;

  logic       core_req;
  logic       pick_core;
  logic [2:0] f_func3;
  logic       f_wr;
  logic [1:0] f_lo;
  logic [31:0] f_wdata;
  logic [LANES-1:0] f_we;
  logic [31:0] f_wdata_sh;
  logic [31:0] f_rdata_ext;
  logic       f_misaligned;

  // Byte address bits above the RAM's reach are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^core_addr[31:ADDR_WIDTH+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign core_err = err_pulse;
`else
  logic unused_err;
  assign unused_err = err_pulse;
`endif

  // Round-robin: a lone requester wins; on a tie the side that did not
  // win last time goes first (core wins the first tie after reset).
  assign core_req  = core_read | core_write;
  assign pick_core = core_req && (!ldr_valid || last_grant == GNT_LDR);

  // The formatter sees the candidate request while idle (to build the
  // store lanes registered into ISSUE) and the latched access afterwards
  // (to extract the load data). Loader traffic is always an aligned word.
  always_comb begin
    f_func3 = func3_q;
    f_wr    = wr_q;
    f_lo    = lo_q;
    f_wdata = '0;
    if (state == IDLE) begin
      if (pick_core) begin
        f_func3 = core_func3;
        f_wr    = core_write;
        f_lo    = core_addr[1:0];
        f_wdata = core_wdata;
      end else begin
        f_func3 = F3_W;
        f_wr    = ldr_write;
        f_lo    = 2'b00;
        f_wdata = ldr_wdata;
      end
    end
  end

  dmem_lane_fmt u_fmt (
    .func3      (f_func3),
    .is_write   (f_wr),
    .addr_lo    (f_lo),
    .wdata      (f_wdata),
    .rdata      (mem_rdata),
    .we         (f_we),
    .wdata_sh   (f_wdata_sh),
    .rdata_ext  (f_rdata_ext),
    .misaligned (f_misaligned)
  );

  // Per-access FSM. Every output is a register: mem_en/mem_we are set on
  // entry to ISSUE so they are high for exactly the ISSUE cycle, and the
  // ready pulses are set on entry to DONE so they are high during DONE.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      last_grant <= GNT_LDR;
      gnt        <= GNT_CORE;
      wr_q       <= 1'b0;
      func3_q    <= '0;
      lo_q       <= '0;
      cnt        <= '0;
      trap_q     <= 1'b0;
      err_pulse  <= 1'b0;
      core_rdata <= '0;
      core_ready <= 1'b0;
      ldr_rdata  <= '0;
      ldr_ready  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= '0;
      core_ready <= 1'b0;
      ldr_ready  <= 1'b0;
      err_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (core_req || ldr_valid) begin
            gnt       <= pick_core ? GNT_CORE : GNT_LDR;
            wr_q      <= f_wr;
            func3_q   <= f_func3;
            lo_q      <= f_lo;
            mem_addr  <= pick_core ? core_addr[ADDR_WIDTH+1:2] : ldr_addr;
            mem_wdata <= f_wdata_sh;
            trap_q    <= f_misaligned & TRAP_EN;
            if (!(f_misaligned & TRAP_EN)) begin
              mem_en <= 1'b1;
              if (f_wr) mem_we <= f_we;
            end
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (trap_q) begin
            core_ready <= 1'b1;
            err_pulse  <= 1'b1;
            core_rdata <= '0;
            state      <= DONE;
          end else if (wr_q) begin
            core_ready <= (gnt == GNT_CORE);
            ldr_ready  <= (gnt == GNT_LDR);
            state      <= DONE;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            if (gnt == GNT_CORE) begin
              core_rdata <= f_rdata_ext;
              core_ready <= 1'b1;
            end else begin
              ldr_rdata <= f_rdata_ext;
              ldr_ready <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        DONE: begin
          last_grant <= gnt;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a latency-LAT
// RAM model, a byte-level reference memory, directed vectors, reset and
// contention sequences, and randomized single-requester traffic.
// Honours DMEM_MISALIGN_TRAP_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int AW  = 12;
  localparam int LAT = 3;
  localparam int RL  = 2 + LAT;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN;
  logic          core_read, core_write;
  logic [2:0]    core_func3;
  logic [31:0]   core_addr, core_wdata, core_rdata;
  logic          core_ready;
  logic          core_err;
  logic          ldr_valid, ldr_write;
  logic [AW-1:0] ldr_addr;
  logic [31:0]   ldr_wdata, ldr_rdata;
  logic          ldr_ready;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rstN(rstN),
    .core_read(core_read), .core_write(core_write), .core_func3(core_func3),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_ready(core_ready),
`ifdef DMEM_MISALIGN_TRAP_EN
    .core_err(core_err),
`endif
    .ldr_valid(ldr_valid), .ldr_write(ldr_write), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata), .ldr_ready(ldr_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

`ifndef DMEM_MISALIGN_TRAP_EN
  assign core_err = 1'b0;
`endif

  // RAM macro model: byte-enabled writes, read data appears LAT cycles
  // after the enable; junk is shifted in otherwise so mistimed captures show.
  logic [31:0] ram [0:4095] = '{default: 32'h0};
  logic [31:0] rd_pipe [0:LAT-1] = '{default: 32'h0};
  assign mem_rdata = rd_pipe[LAT-1];

  always @(posedge clk) begin
    if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= (mem_en && mem_we == 4'b0) ? ram[mem_addr] : $urandom;
  end

  // Reference memory, byte addressed.
  logic [7:0] gold [0:16383];

  int checks = 0;
  int errors = 0;

  int          obs_lat, obs_en;
  logic [3:0]  obs_we;
  logic [AW-1:0] obs_addr;
  logic [31:0] obs_wdata, obs_rdata;
  logic        obs_err;
  logic [31:0] last_core, last_ldr;

  function automatic int access_size(input bit wr, input logic [2:0] f3);
    if (f3 == 3'b000 || (!wr && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!wr && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic int core_base(input logic [31:0] addr, input int size);
    return int'(addr[13:0]) & ~(size - 1);
  endfunction

  function automatic logic [31:0] model_load(input int base, input int size, input bit sgn);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < size; i++) v = v | (32'(gold[base+i]) << (8*i));
    if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
    return v;
  endfunction

  task automatic model_store(input int base, input int size, input logic [31:0] data);
    for (int i = 0; i < size; i++) gold[base+i] = data[8*i +: 8];
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One transaction from one requester, started in an IDLE cycle (cycle 0).
  // Leaves the bench one cycle after the ready pulse, i.e. back in IDLE.
  task automatic applyStimulus(input bit is_ldr, input bit wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
    bit done = 1'b0;
    obs_en = 0; obs_lat = -1; obs_err = 1'b0;
    if (is_ldr) begin
      ldr_valid = 1'b1; ldr_write = wr; ldr_addr = addr[AW-1:0]; ldr_wdata = wd;
    end else begin
      core_read = !wr; core_write = wr; core_func3 = f3; core_addr = addr; core_wdata = wd;
    end
    for (int n = 1; n <= 40 && !done; n++) begin
      @(posedge clk); #1;
      if (mem_en) begin
        obs_en++; obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
      end
      if (is_ldr ? ldr_ready : core_ready) begin
        done = 1'b1; obs_lat = n;
        obs_rdata = is_ldr ? ldr_rdata : core_rdata;
        obs_err = core_err;
      end
    end
    core_read = 1'b0; core_write = 1'b0; ldr_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL ready_timeout actual=none expected=pulse");
    end
    @(posedge clk); #1;
  endtask

  task automatic pulseReset();
    rstN = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstN = 1'b1;
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd;
    logic [11:0] exp_maddr;
    int          exp_lat;
    int          exp_en;
    bit          exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit r_ldr, r_wr, trap;
    logic [2:0] r_f3;
    logic [31:0] r_addr, r_wd, expv;
    int sz, base, c_at, l_at, pulses;
    logic [31:0] c_rd, l_rd;
    int order[$];

    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        4'hF, 32'hDEADBEEF, 12'd4, 2,  1, 1'b0};
    vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 4'h0, 32'h0,        12'd4, RL, 1, 1'b0};
    vecs[2]  = '{1'b1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0,        4'hF, 32'h80FF7F01, 12'd8, 2,  1, 1'b0};
    vecs[3]  = '{1'b0, 3'b000, 32'h23, 32'h0,        32'hFFFFFF80, 4'h0, 32'h0,        12'd8, RL, 1, 1'b0};
    vecs[4]  = '{1'b0, 3'b100, 32'h23, 32'h0,        32'h00000080, 4'h0, 32'h0,        12'd8, RL, 1, 1'b0};
    vecs[5]  = '{1'b0, 3'b001, 32'h22, 32'h0,        32'hFFFF80FF, 4'h0, 32'h0,        12'd8, RL, 1, 1'b0};
    vecs[6]  = '{1'b0, 3'b101, 32'h20, 32'h0,        32'h00007F01, 4'h0, 32'h0,        12'd8, RL, 1, 1'b0};
    vecs[7]  = '{1'b1, 3'b000, 32'h21, 32'h000000AA, 32'h0,        4'h2, 32'hAAAAAAAA, 12'd8, 2,  1, 1'b0};
    vecs[8]  = '{1'b0, 3'b010, 32'h20, 32'h0,        32'h80FFAA01, 4'h0, 32'h0,        12'd8, RL, 1, 1'b0};
    vecs[9]  = '{1'b1, 3'b001, 32'h26, 32'h00001234, 32'h0,        4'hC, 32'h12341234, 12'd9, 2,  1, 1'b0};
    vecs[10] = '{1'b0, 3'b010, 32'h24, 32'h0,        32'h12340000, 4'h0, 32'h0,        12'd9, RL, 1, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs[11] = '{1'b0, 3'b010, 32'h22, 32'h0,        32'h00000000, 4'h0, 32'h0,        12'd8, 2,  0, 1'b1};
`else
    vecs[11] = '{1'b0, 3'b010, 32'h22, 32'h0,        32'h80FFAA01, 4'h0, 32'h0,        12'd8, RL, 1, 1'b0};
`endif

    for (int i = 0; i < 16384; i++) gold[i] = 8'h0;
    core_read = 0; core_write = 0; core_func3 = 0; core_addr = 0; core_wdata = 0;
    ldr_valid = 0; ldr_write = 0; ldr_addr = 0; ldr_wdata = 0;
    rstN = 1'b0;
    last_core = 32'h0; last_ldr = 32'h0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_mem_en", {31'b0, mem_en}, 32'h0);
    checkOutput("reset_mem_we", {28'b0, mem_we}, 32'h0);
    checkOutput("reset_mem_addr", {20'b0, mem_addr}, 32'h0);
    checkOutput("reset_ready", {30'b0, core_ready, ldr_ready}, 32'h0);
    checkOutput("reset_rdata", core_rdata | ldr_rdata | mem_wdata, 32'h0);
    rstN = 1'b1;

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd);
      checkOutput($sformatf("vec%0d_latency", i), obs_lat, vecs[i].exp_lat);
      checkOutput($sformatf("vec%0d_en_count", i), obs_en, vecs[i].exp_en);
      checkOutput($sformatf("vec%0d_err", i), {31'b0, obs_err}, {31'b0, vecs[i].exp_err});
      if (vecs[i].exp_en != 0)
        checkOutput($sformatf("vec%0d_mem_addr", i), {20'b0, obs_addr}, {20'b0, vecs[i].exp_maddr});
      if (vecs[i].wr) begin
        checkOutput($sformatf("vec%0d_mem_we", i), {28'b0, obs_we}, {28'b0, vecs[i].exp_we});
        checkOutput($sformatf("vec%0d_mem_wdata", i), obs_wdata, vecs[i].exp_wd);
        sz = access_size(1'b1, vecs[i].f3);
        model_store(core_base(vecs[i].addr, sz), sz, vecs[i].wd);
      end else begin
        checkOutput($sformatf("vec%0d_rdata", i), obs_rdata, vecs[i].exp_rd);
      end
    end

    // Reset while ISSUE drives a write: strobes must drop at once and the
    // write must never reach the RAM.
    core_write = 1'b1; core_func3 = 3'b010; core_addr = 32'h30; core_wdata = 32'h11223344;
    @(posedge clk); #1;
    checkOutput("issue_mem_en_before_reset", {31'b0, mem_en}, 32'h1);
    rstN = 1'b0; #1;
    checkOutput("async_reset_mem_en", {31'b0, mem_en}, 32'h0);
    checkOutput("async_reset_mem_we", {28'b0, mem_we}, 32'h0);
    core_write = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;

    // Reset during WAIT: no ready pulse afterwards
    core_read = 1'b1; core_func3 = 3'b010; core_addr = 32'h10;
    for (int n = 0; n < 3; n++) begin @(posedge clk); #1; end
    rstN = 1'b0; #1;
    checkOutput("wait_reset_mem_en", {31'b0, mem_en}, 32'h0);
    checkOutput("wait_reset_ready", {31'b0, core_ready}, 32'h0);
    core_read = 1'b0;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      if (n == 1) rstN = 1'b1;
      if (core_ready || ldr_ready) pulses++;
    end
    checkOutput("abort_no_ready", pulses, 0);
    last_core = 32'h0; last_ldr = 32'h0;
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h30, 32'h0);
    checkOutput("fresh_latency", obs_lat, RL);
    checkOutput("fresh_rdata_no_aborted_write", obs_rdata, model_load(48, 4, 1'b0));

    // Both requesters on the first cycle after reset
    pulseReset();
    core_read = 1'b1; core_func3 = 3'b010; core_addr = 32'h10;
    ldr_valid = 1'b1; ldr_write = 1'b0; ldr_addr = 12'd4;
    c_at = -1; l_at = -1; c_rd = 32'h0; l_rd = 32'h0;
    for (int n = 1; n <= 60 && l_at < 0; n++) begin
      @(posedge clk); #1;
      if (core_ready && c_at < 0) begin c_at = n; c_rd = core_rdata; core_read = 1'b0; end
      if (ldr_ready && l_at < 0) begin l_at = n; l_rd = ldr_rdata; ldr_valid = 1'b0; end
    end
    core_read = 1'b0; ldr_valid = 1'b0;
    @(posedge clk); #1;
    expv = model_load(16, 4, 1'b0);
    checkOutput("contend_core_cycle", c_at, RL);
    checkOutput("contend_ldr_cycle", l_at, RL + 1 + RL);
    checkOutput("contend_core_rdata", c_rd, expv);
    checkOutput("contend_ldr_rdata", l_rd, expv);

    // Both held: strict alternation C,L,C,L,C,L (0 = core, 1 = loader)
    core_read = 1'b1; ldr_valid = 1'b1;
    for (int n = 0; n < 80 && order.size() < 6; n++) begin
      @(posedge clk); #1;
      if (core_ready && ldr_ready) order.push_back(2);
      else if (core_ready) order.push_back(0);
      else if (ldr_ready) order.push_back(1);
    end
    core_read = 1'b0; ldr_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("alt_grants", order.size(), 6);
    foreach (order[i]) checkOutput($sformatf("alt_grant%0d", i), order[i], i % 2);
    last_core = expv; last_ldr = expv;

    // Randomized single-requester traffic against the reference memory
    for (int k = 0; k < 150; k++) begin
      r_ldr = 1'($urandom_range(0, 1));
      r_wr  = 1'($urandom_range(0, 1));
      r_f3  = 3'($urandom_range(0, 7));
      r_wd  = $urandom;
      if (r_ldr) begin
        r_addr = 32'($urandom_range(0, 15));
        sz = 4; base = int'(r_addr) * 4;
        trap = 1'b0;
      end else begin
        r_addr = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
        sz = access_size(r_wr, r_f3);
        base = core_base(r_addr, sz);
        trap = TRAP && ((sz == 2 && r_addr[0]) || (sz == 4 && r_addr[1:0] != 2'b00));
      end
      applyStimulus(r_ldr, r_wr, r_f3, r_addr, r_wd);
      checkOutput($sformatf("rnd%0d_latency", k), obs_lat, (trap || r_wr) ? 2 : RL);
      checkOutput($sformatf("rnd%0d_en_count", k), obs_en, trap ? 0 : 1);
      if (trap) begin
        checkOutput($sformatf("rnd%0d_trap_err", k), {31'b0, obs_err}, 32'h1);
        checkOutput($sformatf("rnd%0d_trap_rdata", k), obs_rdata, 32'h0);
        last_core = 32'h0;
      end else if (r_wr) begin
        model_store(base, sz, r_wd);
      end else begin
        expv = model_load(base, sz, !r_ldr && !r_f3[2]);
        checkOutput($sformatf("rnd%0d_rdata", k), obs_rdata, expv);
        if (r_ldr) last_ldr = expv; else last_core = expv;
      end
      if (r_ldr) checkOutput($sformatf("rnd%0d_core_rdata_hold", k), core_rdata, last_core);
      else       checkOutput($sformatf("rnd%0d_ldr_rdata_hold", k), ldr_rdata, last_ldr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
